result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have: clk  in  1  clock, rising-edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: mode_mul, mode_div, mode_sqr  in  1 each  operation select; 000=ALU, 100=MUL, 010=DIV, 001=SQR, others invalid; held stable by the controller.
REQ-004 SHALL have: alu_done  in  1  /  alu_res  in  5  ALU sum with carry.
REQ-005 SHALL have: mul_done  in  1  /  mul_res  in  8  product.
REQ-006 SHALL have: div_done  in  1  /  div_res  in  8  {quotient,remainder}, bit-reversed (div_res[0] is true bit 7).
REQ-007 SHALL have: sqr_done  in  1  /  sqr_res  in  4  root.
REQ-008 SHALL have: out_ack  in  1  display consumed result.
REQ-009 SHALL have: err_clr  in  1  clears err_sticky.
REQ-010 SHALL have: out_result  out  8  formatted result; out_src  out  2  source code (00 ALU, 01 MUL, 10 DIV, 11 SQR).
REQ-011 SHALL have: out_valid  out  1; busy  out  1; err_sticky  out  1.

Function
REQ-012 Formatting SHALL be: ALU {3'b0,alu_res}; MUL mul_res; DIV out_result[i]=div_res[7-i]; SQR {4'b0,sqr_res}.
REQ-013 Only the done of the source selected by the mode inputs is accepted; a done from any other source, or any done under invalid mode, SHALL be discarded and set err_sticky.
REQ-014 States SHALL be IDLE, HOLD, HOLD_FULL.
REQ-015 IDLE: accepted done at edge N -> out_result/out_src loaded, out_valid=1 after edge N (latency 1), state HOLD.
REQ-016 HOLD/HOLD_FULL: out_result and out_src SHALL stay stable while out_valid=1 and out_ack=0.
REQ-017 HOLD, out_ack=1, no accepted done -> out_valid=0 after the edge, state IDLE.
REQ-018 HOLD, out_ack=0, accepted done -> result stored in a one-entry pending buffer, state HOLD_FULL.
REQ-019 HOLD, out_ack=1 and accepted done in the same cycle -> new result loaded directly to outputs, out_valid stays 1, state HOLD.
REQ-020 HOLD_FULL, out_ack=1 -> pending result moves to outputs at that edge, out_valid stays 1, state HOLD; a simultaneous accepted done SHALL be stored as the new pending entry (state stays HOLD_FULL).
REQ-021 HOLD_FULL, out_ack=0, accepted done -> new result dropped, err_sticky set, held and pending data unchanged.
REQ-022 out_ack while out_valid=0 SHALL be ignored.
REQ-023 Mode change while HOLD/HOLD_FULL SHALL NOT alter held or pending data or source codes.
REQ-024 busy SHALL equal out_valid OR pending-valid, registered.
REQ-025 err_sticky SHALL clear on err_clr; a set event in the same cycle wins.

Reset
REQ-026 rst SHALL force state IDLE, out_result=0, out_src=00, out_valid=0, busy=0, err_sticky=0, pending cleared.
REQ-027 rst asserted mid-HOLD/HOLD_FULL SHALL discard held and pending results; no result reappears after release.
REQ-028 First capture after rst deassertion SHALL be possible on the first clock edge.

Structure
REQ-029 Shared package SHALL hold mode encodings, source codes (2 bits), and state encodings.
REQ-030 Formatting (REQ-012) SHALL be one combinational sub-module, res_fmt, instantiated once per input path into the capture mux.

Verification
REQ-031 Mode 000, alu_done with alu_res=5'b10011 -> next cycle out_result=8'h13, out_src=00, out_valid=1; ack -> out_valid=0.
REQ-032 Mode 010, div_res=8'b00000001 -> out_result=8'h80, out_src=10.
REQ-033 Mode 100, mul_done 8'h2A (no ack), then mul_done 8'h51 -> HOLD_FULL; ack -> out_result=8'h51, out_valid stays 1; second ack -> out_valid=0, busy=0.
REQ-034 Mode 001 with HOLD_FULL, third sqr_done 4'h7 without ack -> dropped, err_sticky=1; err_clr -> 0.
REQ-035 Mode 000, mul_done pulse -> no capture, err_sticky=1; mode 110 with alu_done -> discarded, err_sticky=1.
REQ-036 rst asserted in HOLD_FULL -> all outputs 0 asynchronously; after release no stale result on ack.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: mode encodings, source codes,
// FSM states and the held/pending entry layout.
package result_collector_pkg;

   // Mode inputs packed as {mode_mul, mode_div, mode_sqr}
   localparam logic [2:0] MODE_ALU = 3'b000;
   localparam logic [2:0] MODE_MUL = 3'b100;
   localparam logic [2:0] MODE_DIV = 3'b010;
   localparam logic [2:0] MODE_SQR = 3'b001;

   typedef enum logic [1:0] {
      SRC_ALU = 2'b00,
      SRC_MUL = 2'b01,
      SRC_DIV = 2'b10,
      SRC_SQR = 2'b11
   } src_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_HOLD      = 2'b01,
      ST_HOLD_FULL = 2'b10
   } state_t;

   typedef struct packed {
      src_t       src;
      logic [7:0] res;
   } entry_t;

   // True for the four legal one-hot-or-zero mode patterns
   function automatic logic mode_valid(input logic [2:0] mode);
      return (mode == MODE_ALU) || (mode == MODE_MUL) ||
             (mode == MODE_DIV) || (mode == MODE_SQR);
   endfunction

   // Source selected by a legal mode; invalid modes map to ALU and must be
   // qualified with mode_valid()
   function automatic src_t mode_src(input logic [2:0] mode);
      case (mode)
         MODE_MUL: return SRC_MUL;
         MODE_DIV: return SRC_DIV;
         MODE_SQR: return SRC_SQR;
         default:  return SRC_ALU;
      endcase
   endfunction

endpackage

// File: rtl/result_collector_if.sv
// Bundle of execution-unit results, display handshake and status lines.
interface result_collector_if;
   logic       mode_mul;
   logic       mode_div;
   logic       mode_sqr;
   logic       alu_done;
   logic [4:0] alu_res;
   logic       mul_done;
   logic [7:0] mul_res;
   logic       div_done;
   logic [7:0] div_res;
   logic       sqr_done;
   logic [3:0] sqr_res;
   logic       out_ack;
   logic       err_clr;
   logic [7:0] out_result;
   logic [1:0] out_src;
   logic       out_valid;
   logic       busy;
   logic       err_sticky;

   // Controller / units / display side
   modport master (
      output mode_mul, mode_div, mode_sqr,
      output alu_done, alu_res, mul_done, mul_res,
      output div_done, div_res, sqr_done, sqr_res,
      output out_ack, err_clr,
      input  out_result, out_src, out_valid, busy, err_sticky
   );

   // Collector side
   modport slave (
      input  mode_mul, mode_div, mode_sqr,
      input  alu_done, alu_res, mul_done, mul_res,
      input  div_done, div_res, sqr_done, sqr_res,
      input  out_ack, err_clr,
      output out_result, out_src, out_valid, busy, err_sticky
   );
endinterface

// File: rtl/result_collector_res_fmt.sv
// Combinational formatter turning a raw unit result (zero-extended to 8 bits)
// into the 8-bit display format of its source.
module res_fmt
   import result_collector_pkg::*;
(
   input  src_t       src,
   input  logic [7:0] raw,
   output logic [7:0] res
);

   // Per-source formatting; the divider delivers its bits in reverse order
   always_comb begin
      // NOTE: default assignment first so no path leaves res unassigned (no latch).
      res = raw;
      case (src)
         SRC_ALU: res = {3'b000, raw[4:0]};
         SRC_SQR: res = {4'b0000, raw[3:0]};
         SRC_DIV: for (int i = 0; i < 8; i++) res[i] = raw[7-i];
         default: res = raw;
      endcase
   end

endmodule

// File: rtl/result_collector.sv
// Collects results from four execution units, holds one for the display
// with a one-entry pending buffer behind it, and flags protocol errors.
module result_collector
   import result_collector_pkg::*;
(
   input logic               clk,
   input logic               rst,
   result_collector_if.slave bus
);

   logic [7:0] fmt_alu, fmt_mul, fmt_div, fmt_sqr;
   logic [2:0] mode;
   logic [3:0] done_vec;
   logic [3:0] sel_mask;
   src_t       sel;
   logic       accept;
   logic       bad_done;
   logic       drop;
   entry_t     cand;
   state_t     state;
   entry_t     pend;

   res_fmt u_fmt_alu (.src(SRC_ALU), .raw({3'b000, bus.alu_res}),  .res(fmt_alu));
   res_fmt u_fmt_mul (.src(SRC_MUL), .raw(bus.mul_res),            .res(fmt_mul));
   res_fmt u_fmt_div (.src(SRC_DIV), .raw(bus.div_res),            .res(fmt_div));
   res_fmt u_fmt_sqr (.src(SRC_SQR), .raw({4'b0000, bus.sqr_res}), .res(fmt_sqr));

   assign mode = {bus.mode_mul, bus.mode_div, bus.mode_sqr};
   assign sel  = mode_src(mode);

   // Decide which done is accepted, which are stray, and build the candidate
   always_comb begin
      done_vec           = '0;
      done_vec[SRC_ALU]  = bus.alu_done;
      done_vec[SRC_MUL]  = bus.mul_done;
      done_vec[SRC_DIV]  = bus.div_done;
      done_vec[SRC_SQR]  = bus.sqr_done;
      sel_mask           = 4'b0001 << sel;
      accept             = 1'b0;
      bad_done           = |done_vec;
      if (mode_valid(mode)) begin
         accept   = |(done_vec & sel_mask);
         bad_done = |(done_vec & ~sel_mask);
      end
      cand.src = sel;
      case (sel)
         SRC_MUL: cand.res = fmt_mul;
         SRC_DIV: cand.res = fmt_div;
         SRC_SQR: cand.res = fmt_sqr;
         default: cand.res = fmt_alu;
      endcase
   end

   // A full buffer with no ack has nowhere to put a new result
   assign drop = accept && !bus.out_ack && (state == ST_HOLD_FULL);

   // Hold/pending FSM with registered display outputs and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: pending buffer is reset too, so nothing stale survives a reset.
         state          <= ST_IDLE;
         pend           <= '0;
         bus.out_result <= '0;
         bus.out_src    <= SRC_ALU;
         bus.out_valid  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.err_sticky <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here; every register sees pre-edge values.
         if (bad_done || drop)
            bus.err_sticky <= 1'b1;
         else if (bus.err_clr)
            bus.err_sticky <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  bus.out_result <= cand.res;
                  bus.out_src    <= cand.src;
                  bus.out_valid  <= 1'b1;
                  bus.busy       <= 1'b1;
                  state          <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.out_ack && accept) begin
                  bus.out_result <= cand.res;
                  bus.out_src    <= cand.src;
               end else if (bus.out_ack) begin
                  bus.out_valid  <= 1'b0;
                  bus.busy       <= 1'b0;
                  state          <= ST_IDLE;
               end else if (accept) begin
                  pend           <= cand;
                  state          <= ST_HOLD_FULL;
               end
            end
            ST_HOLD_FULL: begin
               if (bus.out_ack) begin
                  bus.out_result <= pend.res;
                  bus.out_src    <= pend.src;
                  if (accept)
                     pend  <= cand;
                  else
                     state <= ST_HOLD;
               end
            end
            default: begin
               state         <= ST_IDLE;
               bus.out_valid <= 1'b0;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios followed by a
// randomized run checked against a queue-based reference model.
module tb_result_collector;
   import result_collector_pkg::*;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;

   result_collector_if bus ();

   result_collector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: displayed entry is q[0], pending is q[1]
   entry_t q[$];
   logic   err_m;

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   task automatic clear_inputs();
      bus.mode_mul = 0; bus.mode_div = 0; bus.mode_sqr = 0;
      bus.alu_done = 0; bus.alu_res  = '0;
      bus.mul_done = 0; bus.mul_res  = '0;
      bus.div_done = 0; bus.div_res  = '0;
      bus.sqr_done = 0; bus.sqr_res  = '0;
      bus.out_ack  = 0; bus.err_clr  = 0;
   endtask

   task automatic set_mode(input logic [2:0] m);
      {bus.mode_mul, bus.mode_div, bus.mode_sqr} = m;
   endtask

   // One clock edge, then settle away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clear pulses after an edge
   task automatic idle_pulses();
      bus.alu_done = 0; bus.mul_done = 0; bus.div_done = 0; bus.sqr_done = 0;
      bus.out_ack  = 0; bus.err_clr  = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_run++;
      if (bus.out_result !== 8'h00 || bus.out_src !== 2'b00 || bus.out_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got res=%h src=%b v=%b busy=%b err=%b, want all 0",
                  bus.out_result, bus.out_src, bus.out_valid, bus.busy, bus.err_sticky);
      end
   endtask

   // Immediately follows reset release: capture must happen on the first edge
   task automatic test_alu();
      set_mode(MODE_ALU);
      bus.alu_done = 1; bus.alu_res = 5'b10011;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_result !== 8'h13 || bus.out_src !== 2'b00 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL alu_capture: got res=%h src=%b v=%b, want 13/00/1",
                  bus.out_result, bus.out_src, bus.out_valid);
      end
      bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_ack: got v=%b busy=%b, want 0/0", bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_div();
      set_mode(MODE_DIV);
      bus.div_done = 1; bus.div_res = 8'b0000_0001;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_result !== 8'h80 || bus.out_src !== 2'b10 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL div_format: got res=%h src=%b v=%b, want 80/10/1",
                  bus.out_result, bus.out_src, bus.out_valid);
      end
      bus.div_done = 1; bus.div_res = 8'b1100_1010; bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_result !== 8'h53 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL div_ack_and_done: got res=%h v=%b busy=%b, want 53/1/1",
                  bus.out_result, bus.out_valid, bus.busy);
      end
      bus.out_ack = 1;
      tick(); idle_pulses();
   endtask

   task automatic test_mul_full();
      set_mode(MODE_MUL);
      bus.mul_done = 1; bus.mul_res = 8'h2A;
      tick(); idle_pulses();
      bus.mul_done = 1; bus.mul_res = 8'h51;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_result !== 8'h2A || bus.out_src !== 2'b01 || bus.busy !== 1'b1 ||
          bus.err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_pending_hold: got res=%h src=%b busy=%b err=%b, want 2a/01/1/0",
                  bus.out_result, bus.out_src, bus.busy, bus.err_sticky);
      end
      // A mode change while holding must not alter held or pending data
      set_mode(MODE_SQR);
      tick();
      n_run++;
      if (bus.out_result !== 8'h2A || bus.out_src !== 2'b01) begin
         n_fail++;
         $display("FAIL mode_change_hold: got res=%h src=%b, want 2a/01", bus.out_result, bus.out_src);
      end
      bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_result !== 8'h51 || bus.out_src !== 2'b01 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mul_pending_move: got res=%h src=%b v=%b, want 51/01/1",
                  bus.out_result, bus.out_src, bus.out_valid);
      end
      bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_drain: got v=%b busy=%b, want 0/0", bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_sqr_drop();
      set_mode(MODE_SQR);
      bus.sqr_done = 1; bus.sqr_res = 4'h3;
      tick(); idle_pulses();
      bus.sqr_done = 1; bus.sqr_res = 4'h5;
      tick(); idle_pulses();
      bus.sqr_done = 1; bus.sqr_res = 4'h7;
      tick(); idle_pulses();
      n_run++;
      if (bus.err_sticky !== 1'b1 || bus.out_result !== 8'h03 || bus.out_src !== 2'b11) begin
         n_fail++;
         $display("FAIL sqr_drop: got err=%b res=%h src=%b, want 1/03/11",
                  bus.err_sticky, bus.out_result, bus.out_src);
      end
      bus.err_clr = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr: got err=%b, want 0", bus.err_sticky);
      end
      bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_result !== 8'h05 || bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sqr_pending_kept: got res=%h v=%b, want 05/1", bus.out_result, bus.out_valid);
      end
      bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sqr_dropped_gone: got v=%b res=%h, want v=0", bus.out_valid, bus.out_result);
      end
   endtask

   task automatic test_bad_source();
      set_mode(MODE_ALU);
      bus.mul_done = 1; bus.mul_res = 8'hEE;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL wrong_source: got v=%b err=%b, want 0/1", bus.out_valid, bus.err_sticky);
      end
      bus.err_clr = 1;
      tick(); idle_pulses();
      set_mode(3'b110);
      bus.alu_done = 1; bus.alu_res = 5'h1F;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_mode: got v=%b err=%b, want 0/1", bus.out_valid, bus.err_sticky);
      end
      // A set event in the same cycle as a clear must win
      bus.err_clr = 1; bus.alu_done = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.err_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set_wins: got err=%b, want 1", bus.err_sticky);
      end
      bus.err_clr = 1;
      tick(); idle_pulses();
   endtask

   task automatic test_reset_mid();
      set_mode(MODE_MUL);
      bus.mul_done = 1; bus.mul_res = 8'h11;
      tick(); idle_pulses();
      bus.mul_done = 1; bus.mul_res = 8'h22;
      tick(); idle_pulses();
      bus.mul_done = 1; bus.mul_res = 8'h33;
      tick(); idle_pulses();
      #2 rst = 1'b1;
      #1;
      n_run++;
      if (bus.out_result !== 8'h00 || bus.out_src !== 2'b00 || bus.out_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.err_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got res=%h src=%b v=%b busy=%b err=%b, want all 0",
                  bus.out_result, bus.out_src, bus.out_valid, bus.busy, bus.err_sticky);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ack = 1;
      tick(); idle_pulses();
      bus.out_ack = 1;
      tick(); idle_pulses();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_result !== 8'h00) begin
         n_fail++;
         $display("FAIL no_stale_after_reset: got v=%b busy=%b res=%h, want 0/0/00",
                  bus.out_valid, bus.busy, bus.out_result);
      end
   endtask

   task automatic test_random();
      logic [2:0] m;
      int         span;
      logic       acc, bad;
      entry_t     e;
      do_reset();
      q.delete();
      err_m = 1'b0;
      m     = MODE_ALU;
      span  = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (span == 0) begin
            span = $urandom_range(1, 8);
            case ($urandom_range(0, 9))
               0:       m = 3'($urandom_range(0, 7));
               1, 2:    m = MODE_MUL;
               3, 4:    m = MODE_DIV;
               5, 6:    m = MODE_SQR;
               default: m = MODE_ALU;
            endcase
         end
         span--;
         set_mode(m);
         bus.alu_done = ($urandom_range(0, 99) < 30); bus.alu_res = 5'($urandom);
         bus.mul_done = ($urandom_range(0, 99) < 8);  bus.mul_res = 8'($urandom);
         bus.div_done = ($urandom_range(0, 99) < 8);  bus.div_res = 8'($urandom);
         bus.sqr_done = ($urandom_range(0, 99) < 8);  bus.sqr_res = 4'($urandom);
         // Give the selected source a higher chance of reporting
         if ($urandom_range(0, 99) < 25) begin
            if (m == MODE_MUL) bus.mul_done = 1;
            if (m == MODE_DIV) bus.div_done = 1;
            if (m == MODE_SQR) bus.sqr_done = 1;
         end
         bus.out_ack = ($urandom_range(0, 99) < 40);
         bus.err_clr = ($urandom_range(0, 99) < 15);

         // Reference: selected done accepted, every other done is an error
         acc = 1'b0;
         bad = 1'b0;
         e   = '0;
         case (m)
            MODE_ALU: begin
               acc = bus.alu_done; bad = bus.mul_done | bus.div_done | bus.sqr_done;
               e.src = SRC_ALU; e.res = 8'(bus.alu_res);
            end
            MODE_MUL: begin
               acc = bus.mul_done; bad = bus.alu_done | bus.div_done | bus.sqr_done;
               e.src = SRC_MUL; e.res = bus.mul_res;
            end
            MODE_DIV: begin
               acc = bus.div_done; bad = bus.alu_done | bus.mul_done | bus.sqr_done;
               e.src = SRC_DIV; e.res = rev8(bus.div_res);
            end
            MODE_SQR: begin
               acc = bus.sqr_done; bad = bus.alu_done | bus.mul_done | bus.div_done;
               e.src = SRC_SQR; e.res = 8'(bus.sqr_res);
            end
            default: bad = bus.alu_done | bus.mul_done | bus.div_done | bus.sqr_done;
         endcase
         if (bus.out_ack && q.size() > 0) void'(q.pop_front());
         if (acc) begin
            if (q.size() < 2) q.push_back(e);
            else bad = 1'b1;
         end
         if (bad) err_m = 1'b1;
         else if (bus.err_clr) err_m = 1'b0;

         tick(); idle_pulses();

         n_run++;
         if (bus.out_valid !== (q.size() > 0) || bus.busy !== (q.size() > 0) ||
             bus.err_sticky !== err_m) begin
            n_fail++;
            $display("FAIL rand_status cyc %0d: got v=%b busy=%b err=%b, want v=%b busy=%b err=%b",
                     cyc, bus.out_valid, bus.busy, bus.err_sticky,
                     q.size() > 0, q.size() > 0, err_m);
         end
         if (q.size() > 0) begin
            n_run++;
            if (bus.out_result !== q[0].res || bus.out_src !== q[0].src) begin
               n_fail++;
               $display("FAIL rand_data cyc %0d: got res=%h src=%b, want res=%h src=%b",
                        cyc, bus.out_result, bus.out_src, q[0].res, q[0].src);
            end
         end
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst    = 1'b1;
      clear_inputs();
      test_reset();
      test_alu();
      test_div();
      test_mul_full();
      test_sqr_drop();
      test_bad_source();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
